mem_access_ctrl: RTL
====================

// Module: mem_access_ctrl
// PURPOSE
//  Memory-side stage downstream of the unified cache. Consumes unified_cache to_mem_packet_out,
//  performs one access on a synchronous single-port SRAM with a fixed modelled latency, and
//  returns read responses as MEM packets to unified_cache from_mem_packet_in.
//  Writes produce no response. One outstanding request; no pipelining.
// PARAMETERS
//  MEM_PACKET_WIDTH_IN_BITS  70  packet width; layout fixed (below)
//  MEM_ADDR_WIDTH_IN_BITS    12  SRAM word-address width
//  MEM_LATENCY                4  ACCESS-state cycles per request; legal range 2..255
//  Layout: [31:0] data, [63:32] byte addr, [64] type (1 = DATA_PACKET_FLAG), [65] is_write,
//          [66] valid, [69:67] reserved (passed through)
// PORTS
//  clk_in                   in   1    clock
//  reset_in                 in   1    synchronous, active-high reset
//  request_packet_in        in   70   request from cache; [66] = valid
//  request_packet_ack_out   out  1    request accepted this cycle
//  response_packet_out      out  70   read response to cache; [66] = valid
//  response_packet_ack_in   in   1    cache accepted response
//  mem_en_out               out  1    SRAM enable (1-cycle pulse)
//  mem_wr_en_out            out  1    SRAM write enable (only with mem_en_out)
//  mem_addr_out             out  12   word address = addr[13:2]
//  mem_wdata_out            out  32   write data
//  mem_rdata_in             in   32   SRAM read data, registered, valid the cycle after mem_en
// BEHAVIOUR
//  Reset: state IDLE, counter 0, all outputs 0 (including response_packet_out), request reg
//   cleared. Reset mid-ACCESS or mid-RESP aborts: an in-flight write may already have
//   been issued; a pending response is dropped.
//  Reset priority: reset_in beats every other event on the same edge.
//  Handshake: sender holds packet until it sees ack. Receiver acks for exactly one cycle,
//   combinationally, in the cycle it captures.
//  FSM IDLE:
//   - request_packet_in[66]=1 -> request_packet_ack_out=1 this cycle (T0).
//   - Packet captured at the end of T0; counter <- 0; go to ACCESS.
//   - Invalid packet -> no ack, stay in IDLE.
//  FSM ACCESS, T1..T(MEM_LATENCY):
//   - First cycle: mem_en_out=1, mem_wr_en_out=is_write, addr/wdata from captured packet.
//   - Otherwise all mem_* outputs are 0.
//   - Counter increments each cycle.
//   - Final cycle (counter == MEM_LATENCY-1):
//       read  -> latch mem_rdata_in into data field; go to RESP.
//       write -> go to IDLE.
//  FSM RESP:
//   - response_packet_out = captured packet with data = rdata, [66]=1; type, addr,
//     is_write and reserved bits unchanged. Held stable until response_packet_ack_in=1.
//   - On ack: next cycle response_packet_out=0, state IDLE.
//   - ack_in while not in RESP is ignored.
//  Latency:
//   - Read: response valid at T(MEM_LATENCY+1).
//   - Write: next request can be acked at T(MEM_LATENCY+1).
//   - Read turnaround: next ack no earlier than the cycle after the response ack.
//  request_packet_ack_out is never 1 outside IDLE; new requests wait (back-pressure).
//  Counter is 8 bits and never wraps (bounded by MEM_LATENCY <= 255).
//  Address bits [1:0] and [31:14] are ignored.
// TESTING
//  1 Read addr 0x40, MEM_LATENCY=4, SRAM[0x10]=0xDEADBEEF -> ack at T0; mem_en, addr 0x10 at T1;
//    response at T5, data 0xDEADBEEF, [64],[65]=0, [66]=1.
//  2 Write 0x12345678 to 0x80, type=1, then read 0x80 type=1 -> no response for write;
//    read returns 0x12345678 with [64]=1.
//  3 Read with response_packet_ack_in held 0 for 10 cycles -> response stable 10 cycles;
//    second valid request gets no ack until the cycle after the response ack.
//  4 reset_in=1 at T2 of a read -> next cycle all outputs 0, state IDLE; no response ever
//    appears; next request acked normally.
//  5 request_packet_in with [66]=0 and nonzero other bits -> no ack, no mem_en, no response.
//  6 Reserved bits [69:67]=3'b101 on a read -> response carries 3'b101; back-to-back
//    16 random reads/writes vs scoreboard -> all data match.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// ---------------------------------------------------------------------------
// mem_access_ctrl
//
// Memory-side stage behind the unified cache. It accepts one request packet at
// a time and performs a single access on a synchronous single-port SRAM. Each
// access takes a fixed, modelled number of cycles. A read is returned to the
// cache as a response packet. A write completes without producing a response.
//
// Packet layout (MEM_PACKET_WIDTH_IN_BITS = 70):
//   [31:0]  data        [63:32] byte address     [64] type (1 = data packet)
//   [65]    is_write    [66]    valid            [69:67] reserved (passed through)
//
// Ports
//   clk_in                  clock
//   reset_in                synchronous, active-high reset
//   request_packet_in       request from the cache; [66] marks it valid
//   request_packet_ack_out  combinational ack, high in the cycle a request is captured
//   response_packet_out     registered read response; [66] marks it valid
//   response_packet_ack_in  cache has taken the response
//   mem_en_out              SRAM enable, one-cycle pulse per request
//   mem_wr_en_out           SRAM write enable, only together with mem_en_out
//   mem_addr_out            SRAM word address (byte address bits [13:2])
//   mem_wdata_out           SRAM write data
//   mem_rdata_in            SRAM read data, valid from the cycle after mem_en_out
//
// MEM_LATENCY is the number of ACCESS cycles per request. Its legal range is
// 2..255. The lower bound gives registered read data time to arrive before it
// is latched. The upper bound keeps the 8-bit counter from wrapping.
// ---------------------------------------------------------------------------
module mem_access_ctrl #(
  parameter int MEM_PACKET_WIDTH_IN_BITS = 70,
  parameter int MEM_ADDR_WIDTH_IN_BITS   = 12,
  parameter int MEM_LATENCY              = 4
) (
  input  logic                                clk_in,
  input  logic                                reset_in,
  input  logic [MEM_PACKET_WIDTH_IN_BITS-1:0] request_packet_in,
  output logic                                request_packet_ack_out,
  output logic [MEM_PACKET_WIDTH_IN_BITS-1:0] response_packet_out,
  input  logic                                response_packet_ack_in,
  output logic                                mem_en_out,
  output logic                                mem_wr_en_out,
  output logic [MEM_ADDR_WIDTH_IN_BITS-1:0]   mem_addr_out,
  output logic [31:0]                         mem_wdata_out,
  input  logic [31:0]                         mem_rdata_in
);

  localparam int VALID_BIT = 66;
  localparam int WRITE_BIT = 65;
  // Word address starts at byte-address bit 2, and the byte address starts at packet bit 32.
  localparam int WORD_ADDR_LSB = 34;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  localparam logic [7:0] LAST_CNT = 8'(MEM_LATENCY - 1);

  logic [1:0]                          state;
  logic [7:0]                          cnt;
  logic [MEM_PACKET_WIDTH_IN_BITS-1:0] req_q;
  logic                                first_cycle;
  logic                                last_cycle;

  // Read response: the captured request with the data field replaced by the
  // SRAM word. Type, address, is_write and the reserved bits pass through unchanged.
  function automatic logic [MEM_PACKET_WIDTH_IN_BITS-1:0] build_response(
    input logic [MEM_PACKET_WIDTH_IN_BITS-1:0] req,
    input logic [31:0]                         rdata
  );
    logic [MEM_PACKET_WIDTH_IN_BITS-1:0] r;
    r            = req;
    r[31:0]      = rdata;
    r[VALID_BIT] = 1'b1;
    return r;
  endfunction

  assign first_cycle = (state == ACCESS) && (cnt == 8'd0);
  assign last_cycle  = (state == ACCESS) && (cnt == LAST_CNT);

  // Ack only in IDLE. Outside IDLE, a held request waits.
  assign request_packet_ack_out = (state == IDLE) && request_packet_in[VALID_BIT];

  // SRAM controls are driven only in the first ACCESS cycle. At all other
  // times they are zero, so an idle or aborted controller shows a quiet bus.
  assign mem_en_out    = first_cycle;
  assign mem_wr_en_out = first_cycle && req_q[WRITE_BIT];
  assign mem_addr_out  = first_cycle ? req_q[WORD_ADDR_LSB +: MEM_ADDR_WIDTH_IN_BITS] : '0;
  assign mem_wdata_out = first_cycle ? req_q[31:0] : '0;

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state               <= IDLE;
      cnt                 <= 8'd0;
      req_q               <= '0;
      response_packet_out <= '0;
    end else begin
      case (state)
        // IDLE -> ACCESS: capture on the acked cycle
        IDLE: begin
          if (request_packet_ack_out) begin
            req_q <= request_packet_in;
            cnt   <= 8'd0;
            state <= ACCESS;
          end
        end
        // ACCESS -> RESP (read) or IDLE (write) after MEM_LATENCY cycles
        ACCESS: begin
          if (last_cycle) begin
            cnt <= 8'd0;
            if (req_q[WRITE_BIT]) begin
              state <= IDLE;
            end else begin
              response_packet_out <= build_response(req_q, mem_rdata_in);
              state               <= RESP;
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        // RESP -> IDLE once the cache takes the response
        RESP: begin
          if (response_packet_ack_in) begin
            response_packet_out <= '0;
            state               <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
